watch_cu: RTL
=============

# watch_cu

Control unit for the watch datapath. It converts debounced single-cycle button pulses into the datapath's control signals:
- a stop level that freezes the 100 Hz tick while time is being set;
- a one-hot digit select for sec_1..hour_10;
- single-cycle up/down edit pulses;
- a blink flag for the display stage.

It sits directly upstream of the watch datapath and drives its `stop`, `up`, `down` and digit-select inputs. A blink/idle-timeout sub-timer returns the watch to RUN after a period with no button activity.

## Interface
- `BLINK_CNT`, default 25_000_000: clocks per blink half-period (4 Hz toggle at 100 MHz).
- `TIMEOUT_TOGGLES`, default 40: blink toggles with no button action before automatic exit to RUN; 0 disables the timeout.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `btn_mode` in 1: one-cycle pulse; enters or leaves SET.
- `btn_left` in 1: one-cycle pulse; selects the next more-significant digit.
- `btn_right` in 1: one-cycle pulse; selects the next less-significant digit.
- `btn_up` in 1: one-cycle pulse; increments the selected digit.
- `btn_down` in 1: one-cycle pulse; decrements the selected digit.
- `sec_1`, `sec_10`, `min_1`, `min_10`, `hour_1`, `hour_10` out 1 each: one-hot level, high for the selected digit while in SET.
- `stop` out 1: high throughout SET.
- `up` out 1: one-cycle pulse.
- `down` out 1: one-cycle pulse.
- `o_blink` out 1: 1 = selected digit blanked; always 0 in RUN.

## Operation
- States:
  - RUN: watch counting; all selects 0, `stop`=0.
  - SET: `stop`=1; a 3-bit `sel` (0..5) chooses a digit: 0=sec_1, 1=sec_10, 2=min_1, 3=min_10, 4=hour_1, 5=hour_10.
- Only one action is taken per cycle. Priority: `btn_mode` > `btn_left` > `btn_right` > `btn_up` > `btn_down`. Lower-priority pulses in the same cycle are dropped.
- RUN + `btn_mode` → SET with `sel`=0. All other buttons are ignored in RUN.
- SET + `btn_mode` → RUN. `sel` keeps its value internally, but all selects go to 0.
- `btn_left`: `sel`+1, wrapping 5→0.
- `btn_right`: `sel`−1, wrapping 0→5.
- `btn_up` / `btn_down` in SET: one `up` / `down` pulse, `sel` unchanged. `up` and `down` are never high together and never high in RUN.
- Blink timer, active only in SET:
  - Counts 0..BLINK_CNT−1; on the terminal count it toggles `o_blink` and increments the toggle count.
  - Counter, toggle count and `o_blink` clear to 0 on entry to SET and on every accepted left/right/up/down action, so the edited digit is shown immediately.
  - When the toggle count reaches TIMEOUT_TOGGLES (non-zero), the state goes to RUN.
- In RUN, the timer is held at 0 and `o_blink`=0.

## Timing
- All outputs are registered.
- A button pulse sampled at edge N produces its output change from edge N, visible in cycle N+1. `up`/`down` are exactly one cycle wide.
- Reset (async assert, sync release) gives: state RUN, `sel`=0, every output 0, timer and toggle count 0.
- Reset asserted mid-SET drops `stop` and all selects immediately, without waiting for a clock edge.
- `stop` rises in the same cycle the first select goes high, and falls in the same cycle the selects go low.
- Timeout: with no action after entry (or after the last action) at edge E, `o_blink` toggles at edges E+k·BLINK_CNT. At edge E+TIMEOUT_TOGGLES·BLINK_CNT the state becomes RUN and `stop`=0.
- A `btn_mode` arriving on the same edge as the timeout still yields RUN; it must not re-enter SET.
- `btn_up`/`btn_down` arriving on the timeout edge are dropped.

## Structure
- Package `watch_pkg`:
  - state type (RUN, SET);
  - `NUM_DIGITS`=6;
  - select index constants `SEL_SEC_1`..`SEL_HOUR_10`;
  - default timing constants.
- Sub-module `watch_blink_timer`: blink counter, `o_blink` toggle and toggle counter. Inputs `enable` and `restart`; output `timeout` as a single-cycle pulse.
- The top level holds the FSM, the `sel` register, the one-hot decode and the pulse registers.

## Test plan
All scenarios use `BLINK_CNT`=4, `TIMEOUT_TOGGLES`=3.
- Reset then `btn_mode`: next cycle `stop`=1, `sec_1`=1, others 0. Then `btn_up`: `up` high exactly 1 cycle, `down` 0.
- In SET, 6 × `btn_left` from sel 0: selects walk sec_10, min_1, min_10, hour_1, hour_10, sec_1. Then `btn_right` from sel 0: `hour_10`=1.
- Same-cycle `btn_left`+`btn_up`: only sel moves, `up` stays 0. Same-cycle `btn_mode`+`btn_down` in SET: RUN, `down` stays 0.
- Idle in SET: `o_blink` toggles every 4 clocks; at 12 clocks after entry `stop`=0 and selects=0. A `btn_up` at clock 10 postpones the exit to clock 22 and clears `o_blink` at clock 11.
- `btn_up`/`btn_down`/`btn_left` in RUN: all outputs remain 0.
- Assert `rst` low mid-SET between clock edges: `stop`, selects and `o_blink` go 0 before the next edge. After release, `btn_mode` → `sec_1`=1.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch control unit and its blink timer.
package watch_pkg;

  // Top-level operating mode: counting normally, or editing the time.
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 6;

  // Digit select indices, least significant digit first.
  localparam logic [2:0] SEL_SEC_1   = 3'd0;
  localparam logic [2:0] SEL_SEC_10  = 3'd1;
  localparam logic [2:0] SEL_MIN_1   = 3'd2;
  localparam logic [2:0] SEL_MIN_10  = 3'd3;
  localparam logic [2:0] SEL_HOUR_1  = 3'd4;
  localparam logic [2:0] SEL_HOUR_10 = 3'd5;

  // Default timing: 4 Hz blink toggle at 100 MHz, exit after 40 idle toggles.
  localparam int DEF_BLINK_CNT       = 25_000_000;
  localparam int DEF_TIMEOUT_TOGGLES = 40;

  // Move one digit towards the more-significant end, wrapping hour_10 -> sec_1.
  function automatic logic [2:0] sel_left(input logic [2:0] s);
    return (s == SEL_HOUR_10) ? SEL_SEC_1 : s + 3'd1;
  endfunction

  // Move one digit towards the less-significant end, wrapping sec_1 -> hour_10.
  function automatic logic [2:0] sel_right(input logic [2:0] s);
    return (s == SEL_SEC_1) ? SEL_HOUR_10 : s - 3'd1;
  endfunction

endpackage

// File: rtl/watch_blink_timer.sv
// Blink half-period counter, blink flag and idle toggle counter.
// Everything is held clear while disabled, so the flag reads 0 outside SET.
module watch_blink_timer
  import watch_pkg::*;
#(
  parameter int BLINK_CNT       = DEF_BLINK_CNT,
  parameter int TIMEOUT_TOGGLES = DEF_TIMEOUT_TOGGLES
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic o_blink,
  output logic timeout
);

  localparam int CW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
  localparam int TW = $clog2(TIMEOUT_TOGGLES + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CNT - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'((TIMEOUT_TOGGLES > 0) ? TIMEOUT_TOGGLES - 1 : 0);

  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_toggles;
  logic          r_blink;
  logic          w_terminal;

  assign w_terminal = (r_cnt == CNT_LAST);

  // The terminal count that would produce the last allowed toggle is the
  // timeout itself; it is decoded combinationally so the FSM leaves SET on
  // exactly that edge.
  assign timeout = enable && w_terminal && (TIMEOUT_TOGGLES != 0) && (r_toggles == TOG_LAST);

  assign o_blink = r_blink;

  // Count half-periods, toggle the flag and tally toggles; clear on restart/exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_toggles <= '0;
      r_blink   <= 1'b0;
    end else if (!enable || restart || timeout) begin
      r_cnt     <= '0;
      r_toggles <= '0;
      r_blink   <= 1'b0;
    end else if (w_terminal) begin
      r_cnt   <= '0;
      r_blink <= ~r_blink;
      if (TIMEOUT_TOGGLES != 0) begin
        r_toggles <= r_toggles + TW'(1);
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/watch_cu.sv
// Watch control unit: turns debounced button pulses into stop, digit
// select, up/down edit pulses and a blink flag for the display.
module watch_cu
  import watch_pkg::*;
#(
  parameter int BLINK_CNT       = DEF_BLINK_CNT,
  parameter int TIMEOUT_TOGGLES = DEF_TIMEOUT_TOGGLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_up,
  input  logic btn_down,
  output logic sec_1,
  output logic sec_10,
  output logic min_1,
  output logic min_10,
  output logic hour_1,
  output logic hour_10,
  output logic stop,
  output logic up,
  output logic down,
  output logic o_blink
);

  state_t                r_state;
  state_t                w_state_next;
  logic [2:0]            r_sel;
  logic [2:0]            w_sel_next;
  logic                  w_up_next;
  logic                  w_down_next;
  logic                  w_restart;
  logic                  w_timeout;
  logic                  w_timer_en;
  logic [NUM_DIGITS-1:0] w_oh_next;
  logic [NUM_DIGITS-1:0] r_oh;
  logic                  r_stop;
  logic                  r_up;
  logic                  r_down;

  assign w_timer_en = (r_state == ST_SET);

  watch_blink_timer #(
    .BLINK_CNT      (BLINK_CNT),
    .TIMEOUT_TOGGLES(TIMEOUT_TOGGLES)
  ) u_blink_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (w_timer_en),
    .restart(w_restart),
    .o_blink(o_blink),
    .timeout(w_timeout)
  );

  // State and select registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_sel   <= SEL_SEC_1;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
    end
  end

  // One action per cycle, by button priority; the timeout beats every button.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_up_next    = 1'b0;
    w_down_next  = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (btn_mode) begin
          w_state_next = ST_SET;
          w_sel_next   = SEL_SEC_1;
          w_restart    = 1'b1;
        end
      end
      ST_SET: begin
        if (w_timeout) begin
          w_state_next = ST_RUN;
        end else if (btn_mode) begin
          // Restart also clears the blink flag so it is 0 on the first RUN cycle.
          w_state_next = ST_RUN;
          w_restart    = 1'b1;
        end else if (btn_left) begin
          w_sel_next = sel_left(r_sel);
          w_restart  = 1'b1;
        end else if (btn_right) begin
          w_sel_next = sel_right(r_sel);
          w_restart  = 1'b1;
        end else if (btn_up) begin
          w_up_next = 1'b1;
          w_restart = 1'b1;
        end else if (btn_down) begin
          w_down_next = 1'b1;
          w_restart   = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // One-hot digit decode from the next state, so selects and stop move together.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_oh
      assign w_oh_next[gi] = (w_state_next == ST_SET) && (w_sel_next == 3'(gi));
    end
  endgenerate

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oh   <= '0;
      r_stop <= 1'b0;
      r_up   <= 1'b0;
      r_down <= 1'b0;
    end else begin
      r_oh   <= w_oh_next;
      r_stop <= (w_state_next == ST_SET);
      r_up   <= w_up_next;
      r_down <= w_down_next;
    end
  end

  assign sec_1   = r_oh[SEL_SEC_1];
  assign sec_10  = r_oh[SEL_SEC_10];
  assign min_1   = r_oh[SEL_MIN_1];
  assign min_10  = r_oh[SEL_MIN_10];
  assign hour_1  = r_oh[SEL_HOUR_1];
  assign hour_10 = r_oh[SEL_HOUR_10];
  assign stop    = r_stop;
  assign up      = r_up;
  assign down    = r_down;

endmodule
